// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Oversampling UART receiver: 1 start bit, DBIT data bits (LSB first),
// no parity, 1 stop bit. The serial line is synchronised with two flops.
// All counter updates are gated by s_tick, which comes from the shared
// baud tick generator.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   rx            serial line, idle high, asynchronous to clk
//   s_tick        one-clk pulse at OVERSAMPLE x baud
//   rx_dout       last received word, held until the next rx_done_tick
//   rx_done_tick  one-clk strobe marking rx_dout/frame_err valid (FIFO wr_en)
//   frame_err     stop bit was sampled low for the flagged word
//   busy          receiver is in any state other than IDLE
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int DBIT       = 8,
    parameter int OVERSAMPLE = 16,
    parameter int SB_TICK    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            busy
);

    localparam int SMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
    localparam int SW   = (SMAX > 1) ? $clog2(SMAX) : 1;
    localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_ONE  = SW'(1);
    localparam logic [SW-1:0] S_ZERO = SW'(0);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_ONE  = NW'(1);
    localparam logic [NW-1:0] N_ZERO = NW'(0);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [SW-1:0]     s_r, s_s;
    logic [NW-1:0]     n_r, n_s;
    logic [DBIT-1:0]   b_r, b_s;
    logic [DBIT-1:0]   dout_r, dout_s;
    logic              ferr_r, ferr_s;
    logic              done_r, done_s;
    logic              busy_r, busy_s;
    logic              rx_meta_r, rx_sync_r;

    // Two-flop synchroniser for the asynchronous serial line (idle high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            s_r     <= S_ZERO;
            n_r     <= N_ZERO;
            b_r     <= {DBIT{1'b0}};
            dout_r  <= {DBIT{1'b0}};
            ferr_r  <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            s_r     <= s_s;
            n_r     <= n_s;
            b_r     <= b_s;
            dout_r  <= dout_s;
            ferr_r  <= ferr_s;
            done_r  <= done_s;
            busy_r  <= busy_s;
        end
    end

    // Next-state logic: counters only move on s_tick; IDLE exit is immediate.
    always_comb begin
        state_s = state_r;
        s_s     = s_r;
        n_s     = n_r;
        b_s     = b_r;
        dout_s  = dout_r;
        ferr_s  = ferr_r;
        done_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (!rx_sync_r) begin
                    state_s = ST_START;
                    s_s     = S_ZERO;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_START: begin
                if (s_tick) begin
                    if (s_r == S_MID) begin
                        // Line must still be low at mid start bit, else it was a glitch.
                        if (!rx_sync_r) begin
                            state_s = ST_DATA;
                            s_s     = S_ZERO;
                            n_s     = N_ZERO;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        s_s = s_r + S_ONE;
                    end
                end else begin
                    s_s = s_r;
                end
            end

            ST_DATA: begin
                if (s_tick) begin
                    if (s_r == S_BIT) begin
                        s_s = S_ZERO;
                        b_s = {rx_sync_r, b_r[DBIT-1:1]};
                        if (n_r == N_LAST) begin
                            state_s = ST_STOP;
                        end else begin
                            n_s = n_r + N_ONE;
                        end
                    end else begin
                        s_s = s_r + S_ONE;
                    end
                end else begin
                    s_s = s_r;
                end
            end

            ST_STOP: begin
                if (s_tick) begin
                    if (s_r == S_STOP) begin
                        // Word is delivered even on a bad stop bit; frame_err tags it.
                        dout_s  = b_r;
                        ferr_s  = ~rx_sync_r;
                        done_s  = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        s_s = s_r + S_ONE;
                    end
                end else begin
                    s_s = s_r;
                end
            end

            default: begin
                state_s = ST_IDLE;
                s_s     = S_ZERO;
                n_s     = N_ZERO;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    assign rx_dout      = dout_r;
    assign frame_err    = ferr_r;
    assign rx_done_tick = done_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Scoreboard bench for uart_rx with default parameters. Each frame driven on
// rx pushes {frame_err, data} into exp_q; a monitor pops and compares on
// every rx_done_tick. s_tick pulses every 4 clk, so one bit is 64 clk.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BIT_CLK = 64;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       s_tick;
    logic [7:0] rx_dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       busy;

    int         n_vec;
    int         n_err;
    int         n_strobe;
    logic       prev_done;
    logic [8:0] exp_q[$];

    uart_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .s_tick       (s_tick),
        .rx_dout      (rx_dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oversampling tick: one pulse every 4 clk, driven on the falling edge.
    initial begin
        int tcnt;
        tcnt   = 0;
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            s_tick = (tcnt == 3);
            tcnt   = (tcnt + 1) % 4;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compare each strobe against the oldest pending frame.
    initial begin
        logic [8:0] e;
        prev_done = 1'b0;
        n_strobe  = 0;
        forever begin
            @(negedge clk);
            if (rx_done_tick === 1'b1) begin
                n_strobe++;
                chk("strobe_width", {31'd0, prev_done}, 32'd0);
                chk("busy_at_strobe", {31'd0, busy}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rx_dout", {24'd0, rx_dout}, {24'd0, e[7:0]});
                    chk("frame_err", {31'd0, frame_err}, {31'd0, e[8]});
                end
            end
            prev_done = rx_done_tick;
        end
    end

    task automatic hold(input logic v, input int nclk);
        rx = v;
        repeat (nclk) @(negedge clk);
    endtask

    // Drives a complete frame; a bad stop bit is low for 3/4 of the bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        exp_q.push_back({~stop_ok, d});
        hold(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            hold(d[i], BIT_CLK);
        end
        if (stop_ok) begin
            hold(1'b1, BIT_CLK);
        end else begin
            hold(1'b0, 48);
            hold(1'b1, 16);
        end
    endtask

    task automatic wait_strobes(input int target);
        int k;
        k = 0;
        while (n_strobe < target && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("strobe_count", n_strobe, target);
    endtask

    initial begin
        int base;
        n_vec = 0;
        n_err = 0;

        // Reset with rx low and ticks running.
        rst_n = 1'b0;
        rx    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dout", {24'd0, rx_dout}, 32'd0);
        chk("rst_done", {31'd0, rx_done_tick}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rx    = 1'b1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // Nominal frame.
        send_frame(8'hA5, 1'b1);
        hold(1'b1, BIT_CLK);
        wait_strobes(1);

        // Frame error followed by a good frame.
        send_frame(8'h3C, 1'b0);
        hold(1'b1, 2 * BIT_CLK);
        wait_strobes(2);
        send_frame(8'h81, 1'b1);
        hold(1'b1, BIT_CLK);
        wait_strobes(3);

        // Glitch shorter than half a bit: rejected, no strobe.
        base = n_strobe;
        hold(1'b0, 5 * 4);
        hold(1'b1, 200);
        chk("glitch_strobes", n_strobe, base);
        chk("glitch_dout", {24'd0, rx_dout}, 32'h81);
        chk("glitch_busy", {31'd0, busy}, 32'd0);

        // Back-to-back frames, no idle between them.
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        hold(1'b1, BIT_CLK);
        wait_strobes(6);

        // Reset in the middle of data bit 4 of 0xC3.
        base = n_strobe;
        hold(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            hold(((8'hC3 >> i) & 8'h01) != 8'h00, BIT_CLK);
        end
        hold(1'b0, 32);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_dout", {24'd0, rx_dout}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        hold(1'b1, 2 * BIT_CLK);
        chk("midrst_strobes", n_strobe, base);
        chk("midrst_idle_busy", {31'd0, busy}, 32'd0);
        send_frame(8'h5A, 1'b1);
        hold(1'b1, BIT_CLK);
        wait_strobes(base + 1);

        chk("queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver: deserialises the asynchronous serial line into DBIT-wide words, LSB first, with 1 start bit, no parity and 1 stop bit.
- Uses the oversampling tick (s_tick) produced by the codebase's tick generator, running at OVERSAMPLE x baud.
- Each received word is presented with a one-cycle rx_done_tick strobe, which directly drives the write-enable of the RX FIFO.
- Frame errors are flagged alongside the word.

Parameters:
DBIT, 8, data bits per frame (5..9)
OVERSAMPLE, 16, s_tick pulses per bit period (even, >=4)
SB_TICK, 16, s_tick pulses spanned by the stop bit (OVERSAMPLE for 1 stop bit)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
rx  input  1  serial line; idle high; asynchronous to clk
s_tick  input  1  one-clk pulse at OVERSAMPLE x baud (from tick generator)
rx_dout  output  DBIT  last received word; held until next rx_done_tick
rx_done_tick  output  1  one-clk strobe: rx_dout/frame_err valid (FIFO wr_en)
frame_err  output  1  stop bit sampled low for the word flagged by rx_done_tick; held until next rx_done_tick
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n low):
  - State = IDLE; tick counter s = 0; bit counter n = 0; shift register b = 0.
  - Synchroniser flops = 1.
  - Outputs: rx_dout = 0, rx_done_tick = 0, frame_err = 0, busy = 0.
- rx passes through a 2-flop synchroniser (rx_s) before any use. Latency from an rx edge to the FSM seeing it is 2 clk.
- Counter widths:
  - s is $clog2(max(OVERSAMPLE, SB_TICK)) bits.
  - n is $clog2(DBIT) bits (minimum 1).
  - No counter ever wraps past its terminal value.
- The FSM advances counters only on clk cycles where s_tick = 1. All other cycles hold state, except the IDLE exit below.
- IDLE:
  - rx_s == 0 -> START with s = 0. This transition does not need s_tick.
- START:
  - On s_tick with s == OVERSAMPLE/2-1 (mid start bit): if rx_s == 0 -> DATA with s = 0, n = 0; else false start (glitch) -> IDLE, no strobe.
  - Otherwise, on s_tick, s++.
- DATA:
  - On s_tick with s == OVERSAMPLE-1: s = 0, b = {rx_s, b[DBIT-1:1]} (LSB first). Then if n == DBIT-1 -> STOP, else n++.
  - Otherwise, on s_tick, s++.
- STOP:
  - On s_tick with s == SB_TICK-1: rx_dout <= b, frame_err <= ~rx_s, rx_done_tick <= 1 for exactly one clk, -> IDLE.
  - Otherwise, on s_tick, s++.
- rx_done_tick is registered and asserts the clk after the terminal STOP tick. It is never high for 2 consecutive clk.
- A word with a frame error is still delivered (strobe asserted, frame_err = 1). Downstream decides whether to discard it.
- Back-to-back frames: IDLE may exit on the clk immediately after the STOP terminal tick if rx_s is already low. No idle gap is required beyond the stop bit.
- Line held low (break): the frame completes with frame_err = 1. The FSM then re-enters START immediately and repeats, producing 0x00/frame_err words.
- rx_dout and frame_err change only on rx_done_tick or reset.
- Reset mid-frame aborts the frame: no strobe, all outputs forced to their reset values.
- s_tick asserted on consecutive clks is legal; each pulse counts as one tick.

Test Plan:
- Reset: hold rst_n low for 3 clk with rx = 0 and s_tick toggling -> rx_dout = 0x00, rx_done_tick = 0, frame_err = 0, busy = 0. Release with rx = 1 -> busy stays 0.
- Nominal frame: defaults, s_tick every 4 clk, send 0xA5 LSB first with a valid stop bit -> exactly one rx_done_tick, rx_dout = 0xA5, frame_err = 0, busy falls with the strobe.
- Frame error: send 0x3C with the stop bit driven low -> rx_done_tick pulses, rx_dout = 0x3C, frame_err = 1. A following good frame 0x81 -> rx_dout = 0x81, frame_err = 0.
- Glitch rejection: pulse rx low for 5 s_ticks (less than OVERSAMPLE/2) -> FSM returns to IDLE, no rx_done_tick, rx_dout unchanged.
- Back-to-back: send 0x00, 0xFF, 0x55 with no idle between frames -> three strobes in order, values match, each strobe exactly 1 clk wide.
- Reset mid-operation: assert rst_n during data bit 4 of 0xC3, release, then send 0x5A -> no strobe for the aborted frame, next strobe with rx_dout = 0x5A.
